// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32
// Brief    : 32 x 32-bit architectural register file, one write port and two
//            registered read ports. R0 reads as zero; R[SP_INDEX] resets to
//            SP_INIT. Asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_32x32 #(
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_INIT  = 32'h03FF_FFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [4:0]  ADDR_R1,
    input  logic [4:0]  ADDR_R2,
    input  logic [4:0]  ADDR_W,
    input  logic [31:0] DATA_W,
    output logic [31:0] DATA_R1,
    output logic [31:0] DATA_R2
);

    localparam int c_NUM_REGS = 32;

    // One-hot write decode. Index 0 is never decoded because R0 is
    // hardwired to zero and must not have a load enable.
    logic [c_NUM_REGS-1:1] w_wr_dec;
    logic [31:0]           w_regs [c_NUM_REGS];

    // 5-to-32 write-address decode, bits 1..31 only.
    always_comb begin
        w_wr_dec = '0;
        for (int k = 1; k < c_NUM_REGS; k++) begin
            w_wr_dec[k] = (ADDR_W == 5'(k));
        end
    end

    // R0 is a constant zero; it has no storage.
    assign w_regs[0] = 32'h0000_0000;

    generate
        for (genvar i = 1; i < c_NUM_REGS; i++) begin : g_cell
            localparam logic [31:0] c_RST_VAL = (i == SP_INDEX) ? SP_INIT : 32'h0000_0000;

            logic        w_load;
            logic [31:0] r_q;

            assign w_load = WRITE & w_wr_dec[i];

            // Load-enabled register cell with asynchronous reset to its
            // per-index reset value.
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    r_q <= c_RST_VAL;
                end else if (w_load) begin
                    r_q <= DATA_W;
                end
            end

            assign w_regs[i] = r_q;
        end
    endgenerate

    // Registered read ports. They sample the pre-write contents, so a
    // same-edge write to the read address is seen only on a later READ.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_R1 <= 32'h0000_0000;
            DATA_R2 <= 32'h0000_0000;
        end else if (READ) begin
            DATA_R1 <= w_regs[ADDR_R1];
            DATA_R2 <= w_regs[ADDR_R2];
        end
    end

endmodule
`default_nettype wire
